stack_unit: RTL
===============

# stack_unit

Hardware operand stack for the MMIPS stack CPU. It sits directly downstream of the controller's `push_sig` / `pop_sig` / `tos_sig` strobes and beside the datapath's memory/ALU path. It consumes the value the datapath selects via `stack_src`, and returns a registered top-of-stack word that feeds the ALU and the memory write-data path. It owns the stack pointer, overflow/underflow detection and the push/pop/tos sequencing that the datapath otherwise open-codes.

## Interface
- `WIDTH`, default 8: data word width; matches the 8-bit instruction/data path.
- `DEPTH`, default 16: number of stack entries; must be a power of two, ≥ 2.
- `CW`, default $clog2(DEPTH)+1: width of the `count` output.
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `push`, in, 1: push `din` (controller `push_sig`).
- `pop`, in, 1: pop top into `dout` (controller `pop_sig`).
- `tos`, in, 1: copy top into `dout` without popping (controller `tos_sig`).
- `din`, in, WIDTH: value to push (datapath `stack_src` mux output).
- `dout`, out, WIDTH: registered last-read top-of-stack.
- `dout_valid`, out, 1: one-cycle pulse; `dout` was updated this cycle.
- `empty`, out, 1: `count == 0`.
- `full`, out, 1: `count == DEPTH`.
- `count`, out, CW: current number of entries.
- `overflow`, out, 1: sticky; a push was refused because the stack was full.
- `underflow`, out, 1: sticky; a pop or tos was refused because the stack was empty.
- `clr_err`, in, 1: clears `overflow` and `underflow`.

## Operation
- Storage: DEPTH×WIDTH array, written at index `sp`. Top is at `sp-1`. `sp` equals `count`.
- Decoded op priority, per cycle:
  - **replace**: `push & pop`.
  - **push**: `push & !pop`.
  - **pop**: `pop & !push`.
  - **tos**: `tos & !push & !pop`.
  - **idle**: none of the above.
  - `tos` is ignored whenever `push` or `pop` is high.
- **push**
  - Not full: `mem[sp] <= din`, `sp <= sp+1`.
  - Full: no write, `sp` unchanged, `overflow <= 1`.
  - `dout` unchanged and `dout_valid` = 0 in both cases.
- **pop**
  - Not empty: `dout <= mem[sp-1]`, `sp <= sp-1`, `dout_valid <= 1`.
  - Empty: `underflow <= 1`, `dout` unchanged, `dout_valid` = 0.
- **replace**
  - Not empty: `dout <= mem[sp-1]` (old top), `mem[sp-1] <= din`, `sp` unchanged, `dout_valid <= 1`.
  - Empty: `underflow <= 1`, no write, nothing else changes.
  - Valid when full (`count` unchanged, so no overflow).
- **tos**
  - Not empty: `dout <= mem[sp-1]`, `dout_valid <= 1`, `sp` unchanged.
  - Empty: `underflow <= 1`.
- Sticky flags:
  - Set conditions above; they hold until `clr_err` or `rst`.
  - If `clr_err` and a new error occur in the same cycle, the flag ends set (set wins).
- `sp` arithmetic is CW bits wide, with no wrap. Full and empty guards prevent leaving 0..DEPTH.
- Reset:
  - `sp` = 0, `dout` = 0, `dout_valid` = 0, `overflow` = `underflow` = 0.
  - Array contents are not cleared.
  - Reset asserted mid-sequence discards the in-flight op that cycle: no write, no flag change.

## Timing
- All outputs are registered except `empty`, `full` and `count`. Those three are combinational from `sp`, so they are registered-equivalent.
- Read latency: op asserted in cycle N gives `dout` / `dout_valid` in cycle N+1.
- Back-to-back ops are accepted every cycle with no stall and no ready signal. The controller is responsible for not needing one.
- A push in cycle N followed by pop/tos in cycle N+1 returns the pushed value at N+2. No bypass is needed because the write lands at the N edge.
- `empty`, `full` and `count` reflect the post-edge `sp`: after a push at N, `count` increments in N+1.

## Structure
- Shared package `mmips_pkg` holds:
  - `WORD_W` = 8, which is the default source for `WIDTH`.
  - `STACK_DEPTH` = 16.
  - enum `stack_op_t` {`SOP_IDLE`, `SOP_PUSH`, `SOP_POP`, `SOP_TOS`, `SOP_REPLACE`}, used by the internal decode and by the bench's reference model.
- One sub-module, `stack_ram`: DEPTH×WIDTH, one synchronous write port, one asynchronous read port at `sp-1`.
- Pointer, decode and flags stay in `stack_unit`.

## Test plan
- **Reset**: drive `rst` high for 1 cycle. Require `dout` = 0, `count` = 0, `empty` = 1, `full` = 0, flags 0. Then push 8'h11, 8'h22 and pop twice: `dout` = 8'h22 then 8'h11, `dout_valid` high both cycles, `empty` = 1 after.
- **Full boundary**: push 16 values 8'h00..8'h0F, so `full` = 1 and `count` = 16. A 17th push of 8'hFF sets `overflow`, leaves `count` = 16, and a following tos returns 8'h0F.
- **Empty boundary**: on an empty stack, issue pop and then tos. `underflow` = 1, `dout` holds its previous value, `dout_valid` stays 0. `clr_err` for 1 cycle clears `underflow`.
- **Replace**:
  - With stack [8'hA0, 8'hB1] (top 8'hB1), assert push & pop with `din` = 8'hC2. Require `dout` = 8'hB1 next cycle, `count` stays 2, and a tos returns 8'hC2.
  - Replace on a full stack does not set `overflow`.
- **Priority and back-to-back**:
  - tos asserted together with push is ignored: push occurs, no `dout_valid`.
  - Push 8'h5A in cycle N and pop in N+1: `dout` = 8'h5A at N+2.
- **Reset mid-operation**: assert `rst` together with push at `count` = 3. Require `count` = 0, no flag set, and a following pop flags `underflow`.

Source files
------------

// File: rtl/mmips_pkg.sv
// rtl/mmips_pkg.sv - shared MMIPS constants, stack op encoding and op decode
// Purpose: word width and stack depth defaults plus the decoded stack operation
//          type shared by stack_unit and its reference model.
// Ports:   none (package).
package mmips_pkg;

  localparam int WORD_W      = 8;
  localparam int STACK_DEPTH = 16;

  typedef enum logic [2:0] {
    SOP_IDLE,
    SOP_PUSH,
    SOP_POP,
    SOP_TOS,
    SOP_REPLACE
  } stack_op_t;

  // push and pop together form a replace; tos only counts when neither is high.
  function automatic stack_op_t decode_op(input logic i_push, input logic i_pop,
                                          input logic i_tos);
    stack_op_t v_op;
    v_op = SOP_IDLE;
    if (i_push && i_pop)      v_op = SOP_REPLACE;
    else if (i_push)          v_op = SOP_PUSH;
    else if (i_pop)           v_op = SOP_POP;
    else if (i_tos)           v_op = SOP_TOS;
    return v_op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x WIDTH stack storage, sync write, async read
// Purpose: backing array for stack_unit; contents are never reset.
// Ports:   clk      - clock
//          i_we     - write enable
//          i_waddr  - write index
//          i_wdata  - write data
//          i_raddr  - read index (top of stack)
//          o_rdata  - combinational read data
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - MMIPS operand stack with pointer, decode and sticky error flags
// Purpose: push/pop/tos/replace sequencing over stack_ram with a registered
//          top-of-stack output and sticky overflow/underflow flags.
// Ports:   clk, rst            - clock, synchronous active-high reset
//          push, pop, tos, din - operation strobes and push data
//          dout, dout_valid    - registered last-read top, one-cycle update pulse
//          empty, full, count  - occupancy, combinational from the pointer
//          overflow, underflow - sticky error flags
//          clr_err             - clears the sticky flags (a same-cycle error wins)
module stack_unit
  import mmips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    r_sp;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  stack_op_t        w_op;
  logic             w_empty;
  logic             w_full;
  logic             w_reads;
  logic             w_rd_ok;
  logic             w_set_unf;
  logic             w_set_ovf;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_we;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == CW'(DEPTH));

  // Wraps to DEPTH-1 when empty, but every consumer is gated by !w_empty.
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);

  always_comb begin
    w_op      = decode_op(push, pop, tos);
    w_reads   = (w_op == SOP_POP) || (w_op == SOP_TOS) || (w_op == SOP_REPLACE);
    w_rd_ok   = w_reads && !w_empty;
    w_set_unf = w_reads && w_empty;
    w_push_ok = (w_op == SOP_PUSH) && !w_full;
    w_set_ovf = (w_op == SOP_PUSH) && w_full;
    w_pop_ok  = (w_op == SOP_POP) && !w_empty;
    // Reset in the same cycle discards the op, including its array write.
    w_we      = !rst && (w_push_ok || ((w_op == SOP_REPLACE) && !w_empty));
    w_waddr   = (w_op == SOP_REPLACE) ? w_top_idx : r_sp[AW-1:0];
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (din),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_ok;
      if (w_rd_ok) r_dout <= w_rdata;
      if (w_push_ok)     r_sp <= r_sp + CW'(1);
      else if (w_pop_ok) r_sp <= r_sp - CW'(1);
      r_overflow  <= w_set_ovf | (r_overflow  & ~clr_err);
      r_underflow <= w_set_unf | (r_underflow & ~clr_err);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_sp;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule
